// File: rtl/pwm_seq_pkg.sv
// Shared types and default widths for the PWM sample sequencer.
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StWait  = 2'd2,
      StReady = 2'd3
   } state_e;

   localparam int unsigned ACC_W_DEF    = 16;
   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned SAMPLE_W_DEF = 12;
   localparam int unsigned DUTY_W_DEF   = 12;
   localparam int unsigned ROM_LAT_DEF  = 1;
   localparam int unsigned SHIFT        = SAMPLE_W_DEF - DUTY_W_DEF;

endpackage

// File: rtl/pwm_phase_acc.sv
// Phase accumulator: adds step on strobe, otherwise holds; exposes the ROM address slice.
module pwm_phase_acc #(
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              add,
   input  logic [ACC_W-1:0]  step,
   output logic [ADDR_W-1:0] addr
);

   logic [ACC_W-1:0] acc_q, acc_d;

   // Carry out of the top bit is dropped, so the phase wraps silently.
   always_comb begin
      acc_d = acc_q;
      if (add) begin
         acc_d = acc_q + step;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign addr = acc_q[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/pwm_sample_sequencer.sv
// Prefetches waveform samples from ROM into a shadow register and loads them as the PWM duty
// word exactly at the counter wrap.
module pwm_sample_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int unsigned ACC_W    = ACC_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned DUTY_W   = DUTY_W_DEF,
   parameter int unsigned ROM_LAT  = ROM_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [ACC_W-1:0]    step,
   input  logic                period_wrap,
   output logic                rom_rd,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [SAMPLE_W-1:0] rom_data,
   output logic [DUTY_W-1:0]   duty,
   output logic                duty_load,
   output logic                busy,
   output logic                underrun,
   input  logic                underrun_clr
);

   localparam int unsigned Shift = SAMPLE_W - DUTY_W;
   localparam int unsigned CntW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   state_e              state_q, state_d;
   logic [CntW-1:0]     lat_cnt_q, lat_cnt_d;
   logic [DUTY_W-1:0]   shadow_q, shadow_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic                duty_load_q, duty_load_d;
   logic                underrun_q, underrun_d;
   logic                underrun_set;
   logic                acc_add;
   logic                lat_last;
   logic [SAMPLE_W-1:0] sample_shifted;

   assign sample_shifted = rom_data >> Shift;
   assign lat_last       = (lat_cnt_q == CntW'(ROM_LAT - 1));

   pwm_phase_acc #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_phase_acc (
      .clk  (clk),
      .rst  (rst),
      .add  (acc_add),
      .step (step),
      .addr (rom_addr)
   );

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      shadow_d     = shadow_q;
      duty_d       = duty_q;
      duty_load_d  = 1'b0;
      acc_add      = 1'b0;
      underrun_set = 1'b0;

      // Disable overrides everything, including a simultaneous wrap; phase is kept for resume.
      if (state_q != StIdle && !en) begin
         state_d     = StIdle;
         duty_d      = '0;
         duty_load_d = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (en) begin
                  state_d = StFetch;
               end
            end
            StFetch: begin
               lat_cnt_d    = '0;
               underrun_set = period_wrap;
               state_d      = StWait;
            end
            StWait: begin
               underrun_set = period_wrap;
               if (lat_last) begin
                  shadow_d = sample_shifted[DUTY_W-1:0];
                  state_d  = StReady;
               end else begin
                  lat_cnt_d = lat_cnt_q + 1'b1;
               end
            end
            StReady: begin
               if (period_wrap) begin
                  duty_d      = shadow_q;
                  duty_load_d = 1'b1;
                  acc_add     = 1'b1;
                  state_d     = StFetch;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      underrun_d = underrun_set | (underrun_q & ~underrun_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         lat_cnt_q   <= '0;
         shadow_q    <= '0;
         duty_q      <= '0;
         duty_load_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         shadow_q    <= shadow_d;
         duty_q      <= duty_d;
         duty_load_q <= duty_load_d;
         underrun_q  <= underrun_d;
      end
   end

   assign rom_rd    = (state_q == StFetch);
   assign busy      = (state_q != StIdle);
   assign duty      = duty_q;
   assign duty_load = duty_load_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and a randomized run against a
// transaction-level reference model.
module tb_pwm_sample_sequencer;
   import pwm_seq_pkg::*;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst, en, period_wrap, underrun_clr;
   logic [15:0] step;
   logic        rom_rd, duty_load, busy, underrun;
   logic [7:0]  rom_addr;
   logic [11:0] rom_data, duty;

   logic [11:0] rom [256];
   logic [7:0]  a_pipe [LAT];

   int n_pass = 0;
   int n_total = 0;

   // Reference model: "sample becomes ready LAT+1 clocks after a fetch starts"
   logic        m_active, m_load, m_und;
   logic [15:0] m_acc;
   logic [11:0] m_duty;
   int          m_k;

   always #5 clk = ~clk;

   pwm_sample_sequencer #(
      .ROM_LAT (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .step         (step),
      .period_wrap  (period_wrap),
      .rom_rd       (rom_rd),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .duty         (duty),
      .duty_load    (duty_load),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   // ROM with LAT-cycle read latency
   always @(posedge clk) begin
      a_pipe[0] <= rom_addr;
      for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
   end
   assign rom_data = rom[a_pipe[LAT-1]];

   typedef struct {
      logic        rst, en, wrap, clr;
      logic [15:0] step;
      logic [11:0] duty;
      logic        load, busy, rd, und;
      logic [7:0]  addr;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step(input logic r, e, w, c, input logic [15:0] s);
      logic set;
      set = 1'b0;
      m_load = 1'b0;
      if (r) begin
         m_active = 0; m_acc = 0; m_duty = 0; m_und = 0; m_k = 0;
      end else begin
         if (!m_active) begin
            if (e) begin m_active = 1; m_k = LAT + 1; end
         end else if (!e) begin
            m_active = 0; m_duty = 0; m_load = 1;
         end else if (m_k > 0) begin
            set = w;
            m_k--;
         end else if (w) begin
            m_duty = 12'(rom[m_acc[15:8]] >> SHIFT);
            m_load = 1;
            m_acc  = m_acc + s;
            m_k    = LAT + 1;
         end
         m_und = set | (m_und & ~c);
      end
   endtask

   task automatic tick(input logic r, e, w, c, input logic [15:0] s);
      logic exp_rd;
      rst = r; en = e; period_wrap = w; underrun_clr = c; step = s;
      @(posedge clk);
      model_step(r, e, w, c, s);
      #1;
      exp_rd = m_active && (m_k == LAT + 1);
      check("duty", duty, m_duty);
      check("duty_load", duty_load, m_load);
      check("busy", busy, m_active);
      check("rom_rd", rom_rd, exp_rd);
      check("underrun", underrun, m_und);
      if (exp_rd) check("rom_addr", rom_addr, m_acc[15:8]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 12'(i * 16);
      m_active = 0; m_acc = 0; m_duty = 0; m_und = 0; m_k = 0; m_load = 0;

      // rst en wrap clr step | duty load busy rd und addr
      vq.push_back('{1, 0, 0, 0, 16'h0100, 12'd0,  0, 0, 0, 0, 8'd0});
      vq.push_back('{1, 0, 0, 0, 16'h0100, 12'd0,  0, 0, 0, 0, 8'd0});
      vq.push_back('{1, 0, 0, 0, 16'h0100, 12'd0,  0, 0, 0, 0, 8'd0});
      vq.push_back('{0, 0, 0, 0, 16'h0100, 12'd0,  0, 0, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 1, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 1, 0, 16'h0100, 12'd0,  1, 1, 1, 0, 8'd1});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 1, 0, 16'h0100, 12'd0,  0, 1, 0, 1, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 1, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 0, 1, 8'd0});
      vq.push_back('{0, 1, 1, 0, 16'h0100, 12'd16, 1, 1, 1, 1, 8'd2});
      vq.push_back('{0, 1, 0, 1, 16'h0100, 12'd16, 0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd16, 0, 1, 0, 0, 8'd0});
      vq.push_back('{0, 0, 1, 0, 16'h0100, 12'd0,  1, 0, 0, 0, 8'd0});
      vq.push_back('{0, 0, 0, 0, 16'h0100, 12'd0,  0, 0, 0, 0, 8'd0});
      vq.push_back('{0, 1, 0, 0, 16'h0100, 12'd0,  0, 1, 1, 0, 8'd2});

      foreach (vq[i]) begin
         tick(vq[i].rst, vq[i].en, vq[i].wrap, vq[i].clr, vq[i].step);
         check($sformatf("vec%0d duty", i), duty, vq[i].duty);
         check($sformatf("vec%0d load", i), duty_load, vq[i].load);
         check($sformatf("vec%0d busy", i), busy, vq[i].busy);
         check($sformatf("vec%0d rd", i), rom_rd, vq[i].rd);
         check($sformatf("vec%0d und", i), underrun, vq[i].und);
         if (vq[i].rd) check($sformatf("vec%0d addr", i), rom_addr, vq[i].addr);
      end

      // Phase wrap: 0 -> FF80 -> FF00 (carry dropped)
      tick(1, 0, 0, 0, 16'hFF80);
      repeat (5) tick(0, 1, 0, 0, 16'hFF80);
      tick(0, 1, 1, 0, 16'hFF80);
      check("t3 addr1", rom_addr, 8'hFF);
      check("t3 load1", duty_load, 1'b1);
      repeat (4) tick(0, 1, 0, 0, 16'hFF80);
      tick(0, 1, 1, 0, 16'hFF80);
      check("t3 duty2", duty, 12'hFF0);
      check("t3 addr2", rom_addr, 8'hFF);
      tick(0, 1, 0, 0, 16'hFF80);
      check("t3 no extra load", duty_load, 1'b0);

      // Reset while READY with shadow = ABC, underrun set
      rom[0] = 12'hABC;
      tick(1, 0, 0, 0, 16'h0000);
      repeat (5) tick(0, 1, 0, 0, 16'h0000);
      tick(0, 1, 1, 0, 16'h0000);
      check("t6 duty", duty, 12'hABC);
      tick(0, 1, 0, 0, 16'h0000);
      tick(0, 1, 1, 0, 16'h0000);
      check("t6 und set", underrun, 1'b1);
      repeat (2) tick(0, 1, 0, 0, 16'h0000);
      tick(1, 1, 0, 0, 16'h0000);
      check("t6 rst duty", duty, 12'h000);
      check("t6 rst busy", busy, 1'b0);
      check("t6 rst und", underrun, 1'b0);
      check("t6 rst rd", rom_rd, 1'b0);
      check("t6 rst addr", rom_addr, 8'h00);
      tick(0, 0, 1, 0, 16'h0000);
      check("t6 idle wrap", duty_load, 1'b0);
      rom[0] = 12'h000;

      // Randomized run against the model
      for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
      tick(1, 0, 0, 0, 16'h0000);
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] s;
         s = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 49) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, s);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
